// File: rtl/multicycle_control_if.sv
// Shared encodings and control/memory bundle for the TSC multi-cycle controller.
// Controller drives the master side; datapath/decoder/memory sit on the slave side.
package multicycle_pkg;
  localparam logic [2:0] IT_NOP    = 3'd0;
  localparam logic [2:0] IT_RTYPE  = 3'd1;
  localparam logic [2:0] IT_LOAD   = 3'd2;
  localparam logic [2:0] IT_STORE  = 3'd3;
  localparam logic [2:0] IT_BRANCH = 3'd4;
  localparam logic [2:0] IT_JUMP   = 3'd5;
  localparam logic [2:0] IT_OUTPUT = 3'd6;

  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RT  = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
endpackage

interface multicycle_control_if #(
  parameter int CNT_WIDTH = 16
);
  logic [2:0]           inst_type;
  logic [3:0]           opcode;
  logic [5:0]           func_code;
  logic                 branch_taken;
  logic                 mem_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic                 i_or_d;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 output_active;
  logic [CNT_WIDTH-1:0] num_inst;

  modport master (
    input  inst_type, opcode, func_code,
    input  branch_taken, mem_ack,
    output mem_req, mem_we, i_or_d,
    output ir_write, pc_write, pc_src,
    output reg_write, wb_sel,
    output output_active, num_inst
  );

  modport slave (
    output inst_type, opcode, func_code,
    output branch_taken, mem_ack,
    input  mem_req, mem_we, i_or_d,
    input  ir_write, pc_write, pc_src,
    input  reg_write, wb_sel,
    input  output_active, num_inst
  );
endinterface

// File: rtl/multicycle_control.sv
// TSC multi-cycle control FSM: sequences fetch, decode, execute,
// memory and writeback, and counts retired instructions.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_lwd;
  logic is_reg_jump;
  logic is_link;
  logic retire;

  assign is_lwd = bus.opcode == OP_LWD;

  assign is_reg_jump = bus.opcode == OP_RT &&
    (bus.func_code == FN_JPR ||
     bus.func_code == FN_JRL);

  assign is_link = bus.opcode == OP_JAL ||
    (bus.opcode == OP_RT &&
     bus.func_code == FN_JRL);

  // State and retired-count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        if (bus.mem_ack) state_d = S_ID;
      end
      S_ID: begin
        unique case (bus.inst_type)
          IT_RTYPE, IT_LOAD, IT_STORE,
          IT_BRANCH, IT_JUMP: state_d = S_EX;
          default:            state_d = S_IF;
        endcase
      end
      S_EX: begin
        unique case (bus.inst_type)
          IT_RTYPE: state_d = S_WB;
          IT_LOAD:  state_d = is_lwd ? S_MEM : S_WB;
          IT_STORE: state_d = S_MEM;
          IT_JUMP:  state_d = is_link ? S_WB : S_IF;
          default:  state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          state_d = (bus.inst_type == IT_STORE) ?
            S_IF : S_WB;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_INIT;
    endcase
  end

  // Retire on every return to fetch, except the first one out of INIT
  always_comb begin
    retire = (state_d == S_IF) &&
      (state_q == S_ID || state_q == S_EX ||
       state_q == S_MEM || state_q == S_WB);
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // Control outputs decoded from state and current instruction
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'd0;
    bus.reg_write     = 1'b0;
    bus.wb_sel        = 2'd0;
    bus.output_active = 1'b0;
    unique case (state_q)
      S_IF: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ack;
      end
      S_ID: begin
        bus.pc_write = 1'b1;
        bus.output_active =
          bus.inst_type == IT_OUTPUT;
      end
      S_EX: begin
        if (bus.inst_type == IT_BRANCH) begin
          bus.pc_write = bus.branch_taken;
          bus.pc_src   = 2'd1;
        end else if (bus.inst_type == IT_JUMP) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = is_reg_jump ? 2'd3 : 2'd2;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
        bus.mem_we  = bus.inst_type == IT_STORE;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        if (bus.inst_type == IT_LOAD && is_lwd)
          bus.wb_sel = 2'd1;
        else if (bus.inst_type == IT_JUMP && is_link)
          bus.wb_sel = 2'd2;
      end
      default: ;
    endcase
  end

  assign bus.num_inst = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction
// observed cycle/strobe profiles against a reference profile model.
module tb_multicycle_control;
  import multicycle_pkg::*;

  localparam int W  = 10;
  localparam int NK = 12;

  localparam int K_NOP = 0;
  localparam int K_UND = 1;
  localparam int K_WWD = 2;
  localparam int K_ADD = 3;
  localparam int K_LHI = 4;
  localparam int K_LWD = 5;
  localparam int K_SWD = 6;
  localparam int K_BEQ = 7;
  localparam int K_JMP = 8;
  localparam int K_JAL = 9;
  localparam int K_JPR = 10;
  localparam int K_JRL = 11;

  typedef struct {
    int cyc;
    int fetch;
    int data;
    int we;
    int irw;
    int rw;
    int wbs;
    int oa;
    int pcw;
    int src;
  } prof_t;

  logic clk = 1'b0;
  logic reset_n;

  multicycle_control_if #(.CNT_WIDTH(W)) bus ();

  multicycle_control #(.CNT_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] tt[NK] = '{IT_NOP, 3'd7, IT_OUTPUT,
    IT_RTYPE, IT_LOAD, IT_LOAD, IT_STORE, IT_BRANCH,
    IT_JUMP, IT_JUMP, IT_JUMP, IT_JUMP};
  logic [3:0] op[NK] = '{4'd0, 4'd0, 4'd15, 4'd15,
    4'd6, 4'd7, 4'd8, 4'd1, 4'd9, 4'd10, 4'd15, 4'd15};
  logic [5:0] fn[NK] = '{6'd0, 6'd0, 6'd28, 6'd0,
    6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd25, 6'd26};

  int total = 0;
  int bad = 0;
  int retired = 0;
  bit mon_en = 1'b0;
  prof_t q[$];

  function automatic void chk(string nm, int a, int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endfunction

  // Reference: what one instruction should look like from fetch to retire
  function automatic prof_t model(int k, bit tk,
                                  int dif, int dmem);
    prof_t p;
    int ex, mem, wb;
    ex = 0; mem = 0; wb = 0;
    p = '{default: 0};
    p.fetch = dif + 1;
    p.irw = 1;
    p.pcw = 1;
    case (k)
      K_WWD: p.oa = 1;
      K_ADD, K_LHI: begin ex = 1; wb = 1; end
      K_LWD: begin ex = 1; mem = 1; wb = 1; p.wbs = 1; end
      K_SWD: begin ex = 1; mem = 1; end
      K_BEQ: begin
        ex = 1;
        p.pcw += tk;
        p.src = tk ? 1 : 0;
      end
      K_JMP: begin ex = 1; p.pcw++; p.src = 2; end
      K_JPR: begin ex = 1; p.pcw++; p.src = 3; end
      K_JAL: begin
        ex = 1; wb = 1; p.pcw++; p.src = 2; p.wbs = 2;
      end
      K_JRL: begin
        ex = 1; wb = 1; p.pcw++; p.src = 3; p.wbs = 2;
      end
      default: ;
    endcase
    p.data = mem ? dmem + 1 : 0;
    p.we = (k == K_SWD) ? p.data : 0;
    p.rw = wb;
    p.cyc = p.fetch + 1 + ex + p.data + wb;
    return p;
  endfunction

  // Monitor: slices the output stream into instructions at each fetch start
  prof_t ob;
  bit open = 1'b0;
  bit prev_fetch = 1'b0;

  task automatic finalize();
    prof_t e;
    if (q.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = q.pop_front();
    chk("cycles", ob.cyc, e.cyc);
    chk("fetch_cyc", ob.fetch, e.fetch);
    chk("data_cyc", ob.data, e.data);
    chk("mem_we", ob.we, e.we);
    chk("ir_write", ob.irw, e.irw);
    chk("reg_write", ob.rw, e.rw);
    chk("wb_sel", ob.wbs, e.wbs);
    chk("out_act", ob.oa, e.oa);
    chk("pc_write", ob.pcw, e.pcw);
    chk("pc_src", ob.src, e.src);
    retired++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        bit f;
        f = bus.mem_req && !bus.i_or_d;
        if (f && !prev_fetch) begin
          if (open) finalize();
          open = 1'b1;
          ob = '{default: 0};
          chk("num_inst", int'(bus.num_inst),
              retired % (1 << W));
        end
        prev_fetch = f;
        if (open) begin
          ob.cyc++;
          if (f) ob.fetch++;
          if (bus.mem_req && bus.i_or_d) ob.data++;
          if (bus.mem_we) ob.we++;
          if (bus.ir_write) ob.irw++;
          if (bus.output_active) ob.oa++;
          if (bus.reg_write) begin
            ob.rw++;
            ob.wbs = int'(bus.wb_sel);
          end
          if (bus.pc_write) begin
            ob.pcw++;
            if (bus.pc_src != 2'd0)
              ob.src = int'(bus.pc_src);
          end
        end
      end
    end
  end

  // Wait for a request of the given kind; stray acks meanwhile must be ignored
  task automatic wait_req(input bit data);
    int n;
    n = 0;
    while (!(bus.mem_req && bus.i_or_d == data) && n < 40) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL req_timeout got=none want=%0d", data);
    end
  endtask

  task automatic ack_after(input int d);
    for (int i = 0; i <= d; i++) begin
      bus.mem_ack = (i == d);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic do_inst(input int k, input bit tk,
                         input int dif, input int dmem);
    q.push_back(model(k, tk, dif, dmem));
    wait_req(1'b0);
    bus.inst_type = tt[k];
    bus.opcode = (k == K_UND) ?
      4'($urandom_range(0, 15)) : op[k];
    bus.func_code = (k == K_UND) ?
      6'($urandom_range(0, 63)) : fn[k];
    bus.branch_taken = tk;
    ack_after(dif);
    if (k == K_LWD || k == K_SWD) begin
      wait_req(1'b1);
      ack_after(dmem);
    end
  endtask

  int dir_k[8] = '{K_ADD, K_LWD, K_SWD, K_BEQ,
                   K_BEQ, K_JAL, K_JPR, K_WWD};
  bit dir_t[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  int dir_m[8] = '{0, 3, 1, 0, 0, 0, 0, 0};

  initial begin
    reset_n = 1'b0;
    bus.inst_type = '0;
    bus.opcode = '0;
    bus.func_code = '0;
    bus.branch_taken = 1'b0;
    bus.mem_ack = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_num_inst", int'(bus.num_inst), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_inst(dir_k[i], dir_t[i], 0, dir_m[i]);
    for (int i = 0; i < 250; i++)
      do_inst(int'($urandom_range(0, NK - 1)),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)));
    for (int i = 0; i < 1100; i++)
      do_inst(K_NOP, 1'b0, 0, 0);

    wait_req(1'b0);
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_empty", q.size(), 0);

    // Reset while an LWD data access is waiting for its ack
    bus.inst_type = IT_LOAD;
    bus.opcode = OP_LWD;
    bus.func_code = '0;
    ack_after(0);
    wait_req(1'b1);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_i_or_d", bus.i_or_d, 0);
    chk("mid_rst_mem_we", bus.mem_we, 0);
    chk("mid_rst_reg_write", bus.reg_write, 0);
    chk("mid_rst_num_inst", int'(bus.num_inst), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("init_mem_req", bus.mem_req, 0);
    @(posedge clk);
    #1;
    chk("first_fetch_req", bus.mem_req, 1);
    chk("first_fetch_iord", bus.i_or_d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
